// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_SUB  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_MUL  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle, done pulses WIDTH cycles after start.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {WIDTH'(0), a};
            r_acc    <= '0;
            r_mplier <= b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops finish in one cycle, MUL iterates.
module alu_mc #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned OP_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v
);
    import alu_pkg::*;

    localparam int unsigned AMT_W = $clog2(WIDTH);

    alu_state_e          r_state;
    logic [WIDTH-1:0]    r_result;
    alu_flags_t          r_flags;
    logic                r_out_valid;

    alu_op_e             w_op;
    logic                w_accept;
    logic                w_mul_start;
    logic                w_mul_busy;
    logic                w_mul_done;
    logic [2*WIDTH-1:0]  w_mul_prod;
    alu_flags_t          w_mul_flg;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH:0]      w_shl;
    logic [WIDTH:0]      w_shr;
    logic [AMT_W-1:0]    w_amt;
    logic                w_amt_big;
    logic [WIDTH-1:0]    w_res;
    alu_flags_t          w_flg;

    assign w_op        = alu_op_e'(op);
    assign in_ready    = ((r_state == IDLE) || ((r_state == DONE) && out_ready)) && !w_mul_busy;
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (w_op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    // Extra MSB/LSB on the shift operands captures the last bit shifted out.
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_amt     = b[AMT_W-1:0];
    assign w_amt_big = 32'(w_amt) >= WIDTH;
    assign w_shl     = {1'b0, a} << w_amt;
    assign w_shr     = {a, 1'b0} >> w_amt;

    always_comb begin
        w_res = '0;
        w_flg = '0;
        case (w_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_flg.c = w_sum[WIDTH];
                w_flg.v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_res = a & b;
            OP_NOR:  w_res = ~(a | b);
            OP_NAND: w_res = ~(a & b);
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_flg.c = !w_diff[WIDTH];
                w_flg.v = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: if (!w_amt_big) {w_flg.c, w_res} = w_shl;
            OP_SHR: if (!w_amt_big) {w_res, w_flg.c} = w_shr;
            OP_MUL: w_res = '0;
        endcase
        w_flg.z = (w_res == '0);
        w_flg.n = w_res[WIDTH-1];
    end

    always_comb begin
        w_mul_flg   = '0;
        w_mul_flg.z = (w_mul_prod[WIDTH-1:0] == '0);
        w_mul_flg.n = w_mul_prod[WIDTH-1];
        w_mul_flg.c = |w_mul_prod[2*WIDTH-1:WIDTH];
    end

    // Accept (from IDLE or back-to-back from DONE) takes priority over state-local moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            if (w_op == OP_MUL) begin
                r_state     <= BUSY;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= DONE;
                r_result    <= w_res;
                r_flags     <= w_flg;
                r_out_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                BUSY: if (w_mul_done) begin
                    r_state     <= DONE;
                    r_result    <= w_mul_prod[WIDTH-1:0];
                    r_flags     <= w_mul_flg;
                    r_out_valid <= 1'b1;
                end
                DONE: if (out_ready) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_flags.z;
    assign flag_n    = r_flags.n;
    assign flag_c    = r_flags.c;
    assign flag_v    = r_flags.v;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=18): flags, MUL latency, backpressure, reset and back-to-back flow.
module tb_alu_mc;
    localparam int unsigned W = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          flag_z;
    logic          flag_n;
    logic          flag_c;
    logic          flag_v;

    int checks   = 0;
    int failures = 0;

    alu_mc #(.WIDTH(W), .OP_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    // Checks result, flags {z,n,c,v} and out_valid together.
    task automatic check_out(input string tag, input logic [W-1:0] r, input logic [3:0] f);
        check({tag, "_res"}, 32'(result), 32'(r));
        check({tag, "_flg"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(f));
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic stray;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
        tick();
        tick();
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_ir", 32'(in_ready), 32'd1);
        check("rst_res", 32'(result), 32'd0);
        check("rst_flg", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD wrap to zero
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 18'h3FFFF, 18'h00001);
        tick();
        check_out("add_wrap", 18'h00000, 4'b1010);
        drive(1'b0, 3'b000, '0, '0);
        tick();
        check("add_idle_ov", 32'(out_valid), 32'd0);

        // SUB negative result, then signed overflow
        drive(1'b1, 3'b100, 18'd5, 18'd7);
        tick();
        check_out("sub_neg", 18'h3FFFE, 4'b0100);
        drive(1'b1, 3'b100, 18'h1FFFF, 18'h3FFFF);
        tick();
        check_out("sub_ovf", 18'h20000, 4'b0101);
        drive(1'b0, 3'b000, '0, '0);
        tick();

        // MUL latency; in_valid during BUSY is ignored and operands change after accept
        drive(1'b1, 3'b111, 18'h00200, 18'h00300);
        tick();
        check("mul_ir0", 32'(in_ready), 32'd0);
        drive(1'b1, 3'b000, 18'h00001, 18'h00001);
        stray = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b0) stray = 1'b1;
        end
        check("mul_busy_hs", 32'(stray), 32'd0);
        drive(1'b0, 3'b000, '0, '0);
        tick();
        check_out("mul", 18'h20000, 4'b0110);
        tick();
        check("mul_idle_ov", 32'(out_valid), 32'd0);

        // Backpressure: result held while out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 18'd1, 18'd2);
        tick();
        drive(1'b1, 3'b001, 18'h0F0F0, 18'h0FF00);
        stray = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (result !== 18'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) stray = 1'b1;
            tick();
        end
        check("bp_hold", 32'(stray), 32'd0);
        check_out("bp_add", 18'd3, 4'b0000);
        out_ready = 1'b1;
        #1;
        check("bp_ir", 32'(in_ready), 32'd1);
        tick();
        check_out("bp_and", 18'h0F000, 4'b0000);
        drive(1'b0, 3'b000, '0, '0);
        tick();

        // Reset during BUSY
        drive(1'b1, 3'b111, 18'd3, 18'd5);
        tick();
        drive(1'b0, 3'b000, '0, '0);
        for (int k = 0; k < 7; k++) tick();
        rst_n = 1'b0;
        #1;
        check("rstm_ov", 32'(out_valid), 32'd0);
        check("rstm_res", 32'(result), 32'd0);
        check("rstm_ir", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        check("rstm_no_stale", 32'(stray), 32'd0);

        // Back-to-back single-cycle ops with in_valid held
        drive(1'b1, 3'b000, 18'd1, 18'd1);
        tick();
        check_out("b2b_add", 18'd2, 4'b0000);
        drive(1'b1, 3'b101, 18'd1, 18'd17);
        tick();
        check_out("b2b_shl17", 18'h20000, 4'b0100);
        drive(1'b1, 3'b110, 18'h20000, 18'd18);
        tick();
        check_out("b2b_shr18", 18'h00000, 4'b1000);
        drive(1'b1, 3'b101, 18'h20001, 18'd1);
        tick();
        check_out("shl_c", 18'h00002, 4'b0010);
        drive(1'b1, 3'b110, 18'd3, 18'd1);
        tick();
        check_out("shr_c", 18'h00001, 4'b0010);
        drive(1'b1, 3'b101, 18'd5, 18'd0);
        tick();
        check_out("shl0", 18'd5, 4'b0000);
        drive(1'b1, 3'b010, 18'd0, 18'd0);
        tick();
        check_out("nor", 18'h3FFFF, 4'b0100);
        drive(1'b1, 3'b011, 18'h3FFFF, 18'h3FFFF);
        tick();
        check_out("nand", 18'h00000, 4'b1000);
        drive(1'b1, 3'b000, 18'h1FFFF, 18'h00001);
        tick();
        check_out("add_ovf", 18'h20000, 4'b0101);
        drive(1'b0, 3'b000, '0, '0);
        tick();
        check("end_ov", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
